otp_pad_scheduler: RTL and testbench

//  Sequences the one-time-pad XOR cipher datapath. Buffers pre-loaded pads in a small FIFO.

---
 rtl/otp_pad_scheduler_if.sv | 34 +++
 rtl/otp_pad_scheduler.sv | 107 ++++++++++
 tb/tb_otp_pad_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/otp_pad_scheduler_if.sv
// Handshake bundle between the pad/message sources, the ciphertext consumer and the
// one-time-pad scheduler.
interface otp_pad_scheduler_if #(
    parameter int unsigned MSG_SIZE = 8,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                pad_valid;
    logic [MSG_SIZE-1:0] pad_data;
    logic                pad_ready;
    logic                msg_valid;
    logic [MSG_SIZE-1:0] msg_data;
    logic                msg_ready;
    logic                ct_valid;
    logic [MSG_SIZE-1:0] ct_data;
    logic                ct_ready;
    logic                zeroize;
    logic                zeroize_busy;
    logic [CNT_W-1:0]    pad_count;
    logic [15:0]         msg_count;

    // Sources and consumer side.
    modport master (
        output pad_valid, pad_data, msg_valid, msg_data, ct_ready, zeroize,
        input  pad_ready, msg_ready, ct_valid, ct_data, zeroize_busy, pad_count, msg_count
    );

    // Scheduler side.
    modport slave (
        input  pad_valid, pad_data, msg_valid, msg_data, ct_ready, zeroize,
        output pad_ready, msg_ready, ct_valid, ct_data, zeroize_busy, pad_count, msg_count
    );
endinterface

// File: rtl/otp_pad_scheduler.sv
// One-time-pad scheduler: pad FIFO, single-use pad pairing with each message,
// registered ciphertext output and a one-entry-per-cycle zeroize wipe.
module otp_pad_scheduler #(
    parameter int unsigned MSG_SIZE = 8,
    parameter int unsigned DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    otp_pad_scheduler_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {ST_RUN, ST_ZERO} state_e;

    state_e              state_q;
    logic [MSG_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wipe_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ct_valid_q;
    logic [MSG_SIZE-1:0] ct_data_q;
    logic [15:0]         msg_cnt_q;

    logic pad_ready_c;
    logic msg_ready_c;
    logic push_c;
    logic pop_c;

    // Readies are held low through reset and whenever a wipe is requested or running.
    assign pad_ready_c = rst_n && (state_q == ST_RUN) && !bus.zeroize
                         && (cnt_q < CNT_W'(DEPTH));
    assign msg_ready_c = rst_n && (state_q == ST_RUN) && !bus.zeroize
                         && (cnt_q != CNT_W'(0)) && (!ct_valid_q || bus.ct_ready);
    assign push_c      = bus.pad_valid && pad_ready_c;
    assign pop_c       = bus.msg_valid && msg_ready_c;

    assign bus.pad_ready    = pad_ready_c;
    assign bus.msg_ready    = msg_ready_c;
    assign bus.ct_valid     = ct_valid_q;
    assign bus.ct_data      = ct_data_q;
    assign bus.zeroize_busy = (state_q == ST_ZERO);
    assign bus.pad_count    = cnt_q;
    assign bus.msg_count    = msg_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            wipe_q     <= '0;
            cnt_q      <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
            msg_cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.zeroize) begin
                        // Pending ciphertext is discarded; storage is wiped in ZERO.
                        state_q    <= ST_ZERO;
                        ct_valid_q <= 1'b0;
                        ct_data_q  <= '0;
                        cnt_q      <= '0;
                        rd_ptr_q   <= '0;
                        wr_ptr_q   <= '0;
                        wipe_q     <= '0;
                    end else begin
                        if (push_c) begin
                            mem_q[wr_ptr_q] <= bus.pad_data;
                            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                        end
                        // A consumed pad is erased so it can never be read again.
                        if (pop_c) begin
                            ct_data_q       <= bus.msg_data ^ mem_q[rd_ptr_q];
                            mem_q[rd_ptr_q] <= '0;
                            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
                            msg_cnt_q       <= msg_cnt_q + 16'd1;
                        end
                        if (pop_c) begin
                            ct_valid_q <= 1'b1;
                        end else if (bus.ct_ready) begin
                            ct_valid_q <= 1'b0;
                        end
                        if (push_c && !pop_c) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end else if (pop_c && !push_c) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_ZERO: begin
                    mem_q[wipe_q] <= '0;
                    wipe_q        <= wipe_q + PTR_W'(1);
                    if (wipe_q == PTR_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_otp_pad_scheduler.sv
// Directed bench for otp_pad_scheduler: expected ciphertexts are queued at accept time and
// checked by a separate monitor when the consumer takes them.
module tb_otp_pad_scheduler;
    logic clk;
    logic rst_n;

    otp_pad_scheduler_if #(.MSG_SIZE(8), .DEPTH(4)) bus ();

    otp_pad_scheduler #(.MSG_SIZE(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] exp_ct;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ciphertext handed to the consumer must match the queue head.
    always @(negedge clk) begin
        if (mon_en && rst_n && bus.ct_valid && bus.ct_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ct_unexpected: got 0x%0h expected none", bus.ct_data);
            end else begin
                exp_ct = exp_q.pop_front();
                chk("ct_data", 32'(bus.ct_data), 32'(exp_ct));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pad(input logic [7:0] d);
        bit ok = 1'b0;
        bus.pad_valid = 1'b1;
        bus.pad_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.pad_ready) ok = 1'b1;
            tick();
            if (ok) break;
        end
        bus.pad_valid = 1'b0;
        chk("pad_push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_msg(input logic [7:0] d, input logic [7:0] exp, input bit want);
        bit ok = 1'b0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.msg_ready) begin
                ok = 1'b1;
                if (want) exp_q.push_back(exp);
            end
            tick();
            if (ok) break;
        end
        bus.msg_valid = 1'b0;
        chk("msg_accepted", 32'(ok), 32'd1);
    endtask

    // Message stalls on an empty FIFO until a pad lands, then is accepted the cycle after.
    task automatic stall_then_pad(input logic [7:0] m, input logic [7:0] p, input logic [7:0] exp);
        bus.msg_valid = 1'b1;
        bus.msg_data  = m;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_msg_ready", 32'(bus.msg_ready), 32'd0);
            chk("stall_ct_valid", 32'(bus.ct_valid), 32'd0);
            tick();
        end
        bus.pad_valid = 1'b1;
        bus.pad_data  = p;
        @(negedge clk);
        chk("push_cycle_msg_ready", 32'(bus.msg_ready), 32'd0);
        chk("push_cycle_pad_ready", 32'(bus.pad_ready), 32'd1);
        tick();
        bus.pad_valid = 1'b0;
        @(negedge clk);
        chk("after_push_msg_ready", 32'(bus.msg_ready), 32'd1);
        if (bus.msg_ready) exp_q.push_back(exp);
        tick();
        bus.msg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pad_ready"}, 32'(bus.pad_ready), 32'd0);
        chk({tag, "_msg_ready"}, 32'(bus.msg_ready), 32'd0);
        chk({tag, "_ct_valid"}, 32'(bus.ct_valid), 32'd0);
        chk({tag, "_ct_data"}, 32'(bus.ct_data), 32'd0);
        chk({tag, "_busy"}, 32'(bus.zeroize_busy), 32'd0);
        chk({tag, "_pad_count"}, 32'(bus.pad_count), 32'd0);
        chk({tag, "_msg_count"}, 32'(bus.msg_count), 32'd0);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.pad_valid = 1'b0;
        bus.pad_data  = '0;
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.ct_ready  = 1'b0;
        bus.zeroize   = 1'b0;
        #12;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // 1: two pads, two messages, consumer always ready
        bus.ct_ready = 1'b1;
        push_pad(8'hA5);
        push_pad(8'h3C);
        chk("t1_count_loaded", 32'(bus.pad_count), 32'd2);
        send_msg(8'hFF, 8'h5A, 1'b1);
        chk("t1_ct_latency_valid", 32'(bus.ct_valid), 32'd1);
        chk("t1_ct_latency_data", 32'(bus.ct_data), 32'h5A);
        send_msg(8'h0F, 8'h33, 1'b1);
        tick();
        chk("t1_count_empty", 32'(bus.pad_count), 32'd0);
        chk("t1_msg_count", 32'(bus.msg_count), 32'd2);

        // 2: empty FIFO stalls the message until a pad arrives
        stall_then_pad(8'h11, 8'h22, 8'h33);
        tick();

        // 3: full FIFO refuses a push even when a pop happens in the same cycle
        push_pad(8'h01);
        push_pad(8'h02);
        push_pad(8'h03);
        push_pad(8'h04);
        chk("t3_count_full", 32'(bus.pad_count), 32'd4);
        chk("t3_pad_ready_full", 32'(bus.pad_ready), 32'd0);
        bus.pad_valid = 1'b1;
        bus.pad_data  = 8'h55;
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'h10;
        @(negedge clk);
        chk("t3_pad_ready_pop", 32'(bus.pad_ready), 32'd0);
        chk("t3_msg_ready_pop", 32'(bus.msg_ready), 32'd1);
        if (bus.msg_ready) exp_q.push_back(8'h11);
        tick();
        bus.pad_valid = 1'b0;
        bus.msg_valid = 1'b0;
        chk("t3_count_after", 32'(bus.pad_count), 32'd3);
        tick();

        // 4: back-pressure holds ciphertext; release accepts the next message in the same cycle
        bus.ct_ready = 1'b0;
        send_msg(8'h20, 8'h22, 1'b1);
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'h30;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_msg_ready_blocked", 32'(bus.msg_ready), 32'd0);
            chk("t4_ct_held", 32'(bus.ct_data), 32'h22);
            tick();
        end
        bus.ct_ready = 1'b1;
        @(negedge clk);
        chk("t4_msg_ready_release", 32'(bus.msg_ready), 32'd1);
        if (bus.msg_ready) exp_q.push_back(8'h33);
        tick();
        bus.msg_valid = 1'b0;
        bus.ct_ready  = 1'b0;
        @(negedge clk);
        chk("t4_ct_valid_kept", 32'(bus.ct_valid), 32'd1);
        chk("t4_ct_data_new", 32'(bus.ct_data), 32'h33);
        tick();
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;

        // 5: zeroize with 3 pads and pending ciphertext (FIFO holds 0x04 here)
        push_pad(8'h05);
        push_pad(8'h06);
        send_msg(8'h40, 8'h44, 1'b0);
        push_pad(8'h07);
        chk("t5_count_pre", 32'(bus.pad_count), 32'd3);
        chk("t5_ct_valid_pre", 32'(bus.ct_valid), 32'd1);
        bus.zeroize = 1'b1;
        @(negedge clk);
        chk("t5_pad_ready_zreq", 32'(bus.pad_ready), 32'd0);
        chk("t5_msg_ready_zreq", 32'(bus.msg_ready), 32'd0);
        tick();
        bus.zeroize = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_busy", 32'(bus.zeroize_busy), 32'd1);
            chk("t5_count_zero", 32'(bus.pad_count), 32'd0);
            chk("t5_ct_valid_zero", 32'(bus.ct_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("t5_busy_done", 32'(bus.zeroize_busy), 32'd0);
        chk("t5_msg_count_kept", 32'(bus.msg_count), 32'd7);
        tick();
        bus.ct_ready = 1'b1;
        stall_then_pad(8'h77, 8'h99, 8'hEE);
        tick();
        tick();

        // 6a: reset while ciphertext is pending
        bus.ct_ready = 1'b0;
        push_pad(8'h12);
        send_msg(8'h34, 8'h26, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_output");
        tick();
        rst_n = 1'b1;
        tick();

        // 6b: reset in the middle of a wipe
        push_pad(8'h12);
        bus.zeroize = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        tick();
        chk("t6_busy_mid", 32'(bus.zeroize_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wipe");
        tick();
        rst_n = 1'b1;
        tick();

        // 6c: msg_count wraps after 65536 accepts (zero pads and messages stream through)
        mon_en        = 1'b0;
        bus.ct_ready  = 1'b1;
        bus.pad_valid = 1'b1;
        bus.pad_data  = 8'h00;
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'h00;
        n = 0;
        for (int g = 0; g < 70000 && n < 65535; g++) begin
            @(negedge clk);
            if (bus.msg_ready) n++;
            tick();
        end
        bus.pad_valid = 1'b0;
        bus.msg_valid = 1'b0;
        chk("t6_bulk_accepts", 32'(n), 32'd65535);
        chk("t6_msg_count_max", 32'(bus.msg_count), 32'hFFFF);
        tick();
        exp_q.delete();
        mon_en = 1'b1;
        send_msg(8'h5C, 8'h5C, 1'b1);
        chk("t6_msg_count_wrap", 32'(bus.msg_count), 32'h0000);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
